reglk_guard_regfile: RTL and testbench

- Bus-side consumer of the register-lock scheme: a 6-entry 32-bit register bank whose writes are gated by per-register sticky lock bits.
- Owns the JTAG unlock path, a password-check FSM with an attempt counter and a permanent lockout.
- The JTAG unlock bypasses the locks without clearing them.
- Sits between the debug/bus fabric and the protected configuration registers.

---
 rtl/reglk_guard_regfile.sv | 156 +++++++++++++++
 tb/tb_reglk_guard_regfile.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reglk_guard_regfile.sv
// Lock-guarded register bank: six data registers with sticky per-register write locks,
// plus a JTAG password FSM whose UNLOCKED state bypasses (but never clears) the locks.
module reglk_guard_regfile #(
  parameter int                   NUM_REGS     = 6,
  parameter int                   DATA_W       = 32,
  parameter int                   MAX_ATTEMPTS = 3,
  parameter logic [31:0]          UNLOCK_KEY   = 32'hA5A5_5A5A,
  parameter logic [NUM_REGS-1:0]  LOCK_RST     = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  input  logic                jtag_unlock_valid_i,
  input  logic [31:0]         jtag_unlock_key_i,
  output logic                jtag_unlock_ack_o,
  output logic                jtag_unlock_pass_o,
  output logic                jtag_unlocked_o,
  output logic                jtag_lockout_o,
  output logic [NUM_REGS-1:0] reglk_o
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [3:0] ADDR_LOCK = 4'd6;
  localparam logic [3:0] ADDR_STAT = 4'd7;
  localparam logic [3:0] MAX_CNT   = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UNLOCKED, S_LOCKOUT} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           key_q, key_d;
  logic                  ack_q, ack_d, pass_q, pass_d;
  logic [NUM_REGS-1:0]   reglk_q, reglk_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic                  rvalid_q, err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  wr_en, is_data, unlocked, relock;
  logic [IDX_W-1:0]      idx;

  assign idx      = addr_i[IDX_W-1:0];
  assign is_data  = (addr_i < 4'(NUM_REGS));
  assign unlocked = (state_q == S_UNLOCKED);
  assign relock   = req_i && we_i && (addr_i == ADDR_STAT) && wdata_i[0] && unlocked;

  // All lock decisions below read the registered state, so a same-cycle lock
  // write or unlock never affects a concurrent data write.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    reglk_d = reglk_q;
    if (req_i) begin
      if (is_data) begin
        if (we_i) begin
          if (!reglk_q[idx] || unlocked) wr_en = 1'b1;
          else                           err_d = 1'b1;
        end else begin
          rdata_d = regs_q[idx];
        end
      end else if (addr_i == ADDR_LOCK) begin
        if (we_i) reglk_d = reglk_q | wdata_i[NUM_REGS-1:0];
        else      rdata_d = DATA_W'(reglk_q);
      end else if (addr_i == ADDR_STAT) begin
        if (!we_i) rdata_d = DATA_W'({cnt_q, 2'b00, (state_q == S_LOCKOUT), unlocked});
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (jtag_unlock_valid_i) state_d = S_CHECK;
      S_CHECK: begin
        if (key_q == UNLOCK_KEY)             state_d = S_UNLOCKED;
        else if (cnt_q + 4'd1 == MAX_CNT)    state_d = S_LOCKOUT;
        else                                 state_d = S_IDLE;
      end
      S_UNLOCKED: if (relock) state_d = S_IDLE;
      default:    state_d = S_LOCKOUT;
    endcase
  end

  always_comb begin
    ack_d  = 1'b0;
    pass_d = 1'b0;
    cnt_d  = cnt_q;
    key_d  = key_q;
    case (state_q)
      S_IDLE: if (jtag_unlock_valid_i) key_d = jtag_unlock_key_i;
      S_CHECK: begin
        ack_d = 1'b1;
        if (key_q == UNLOCK_KEY) begin
          pass_d = 1'b1;
          cnt_d  = 4'd0;
        end else begin
          cnt_d  = cnt_q + 4'd1;
        end
      end
      S_UNLOCKED: begin
        ack_d  = jtag_unlock_valid_i;
        pass_d = jtag_unlock_valid_i;
        if (relock) cnt_d = 4'd0;
      end
      default: ack_d = jtag_unlock_valid_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= 4'd0;
      ack_q    <= 1'b0;
      pass_q   <= 1'b0;
      reglk_q  <= LOCK_RST;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      pass_q   <= pass_d;
      reglk_q  <= reglk_d;
      rvalid_q <= req_i;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      if (wr_en) regs_q[idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) key_q <= key_d;

  assign gnt_o              = req_i;
  assign rvalid_o           = rvalid_q;
  assign rdata_o            = rdata_q;
  assign err_o              = err_q;
  assign jtag_unlock_ack_o  = ack_q;
  assign jtag_unlock_pass_o = pass_q;
  assign jtag_unlocked_o    = unlocked;
  assign jtag_lockout_o     = (state_q == S_LOCKOUT);
  assign reglk_o            = reglk_q;

endmodule

// File: tb/tb_reglk_guard_regfile.sv
// Scoreboard bench for reglk_guard_regfile: stimulus pushes expected bus responses and
// unlock acks into queues; negedge monitors pop and compare them against the DUT.
module tb_reglk_guard_regfile;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;
  localparam logic [31:0] BAD = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        jv = 1'b0;
  logic [31:0] jk = '0;
  logic        ack, pass, unl, lko;
  logic [5:0]  reglk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct { logic [31:0] rd; logic er; int at; } bexp_t;
  typedef struct { logic ps; int at; } jexp_t;
  bexp_t bq[$];
  jexp_t jq[$];

  reglk_guard_regfile dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .jtag_unlock_valid_i(jv), .jtag_unlock_key_i(jk), .jtag_unlock_ack_o(ack),
    .jtag_unlock_pass_o(pass), .jtag_unlocked_o(unl), .jtag_lockout_o(lko), .reglk_o(reglk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus response monitor
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (bq.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        bexp_t e;
        e = bq.pop_front();
        chk("rvalid_latency", 32'(cyc), 32'(e.at));
        chk("rdata", rdata, e.rd);
        chk("err", 32'(err), 32'(e.er));
      end
    end else if (bq.size() != 0 && bq[0].at <= cyc) begin
      chk("missing_rvalid", 32'd0, 32'd1);
      void'(bq.pop_front());
    end
  end

  // Unlock ack monitor
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (jq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        jexp_t e;
        e = jq.pop_front();
        chk("ack_latency", 32'(cyc), 32'(e.at));
        chk("ack_pass", 32'(pass), 32'(e.ps));
      end
    end else if (jq.size() != 0 && jq[0].at <= cyc) begin
      chk("missing_ack", 32'd0, 32'd1);
      void'(jq.pop_front());
    end
  end

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; jv = 1'b0; jk = '0;
  endtask

  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_er);
    bexp_t e;
    @(negedge clk);
    jv = 1'b0; req = 1'b1; we = w; addr = a; wdata = d;
    e.rd = exp_rd; e.er = exp_er; e.at = cyc + 1;
    bq.push_back(e);
    #1 chk("gnt", 32'(gnt), 32'd1);
  endtask

  task automatic jtag(input logic [31:0] k, input int lat, input logic exp_pass, input bit expect_ack);
    jexp_t e;
    @(negedge clk);
    req = 1'b0; we = 1'b0; jv = 1'b1; jk = k;
    if (expect_ack) begin
      e.ps = exp_pass; e.at = cyc + lat;
      jq.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; we = 1'b0; jv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bad attempt from IDLE: strobe, CHECK cycle, ack cycle, then status read.
  task automatic bad_try(input logic [31:0] exp_status);
    jtag(BAD, 2, 1'b0, 1'b1);
    idle();
    idle();
    bus(1'b0, 4'd7, '0, exp_status, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_reglk", 32'(reglk), 32'h00);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_unlocked", 32'(unl), 32'd0);
    chk("rst_lockout", 32'(lko), 32'd0);

    // Basic write/read, locking and set-only lock bits
    bus(1'b1, 4'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus(1'b0, 4'd2, '0, 32'hDEAD_BEEF, 1'b0);
    bus(1'b1, 4'd6, 32'h4, 32'h0, 1'b0);
    bus(1'b1, 4'd2, 32'h1234, 32'h0, 1'b1);
    bus(1'b0, 4'd2, '0, 32'hDEAD_BEEF, 1'b0);
    bus(1'b1, 4'd3, 32'h55, 32'h0, 1'b0);
    bus(1'b0, 4'd3, '0, 32'h55, 1'b0);
    bus(1'b1, 4'd6, 32'h0, 32'h0, 1'b0);
    bus(1'b0, 4'd6, '0, 32'h4, 1'b0);
    idle();
    chk("reglk_sticky", 32'(reglk), 32'h04);

    // Three bad keys lead to lockout; the right key is then refused
    bad_try(32'h10);
    bad_try(32'h20);
    bad_try(32'h32);
    chk("lockout_set", 32'(lko), 32'd1);
    jtag(KEY, 1, 1'b0, 1'b1);
    idle();
    idle();
    chk("lockout_held", 32'(lko), 32'd1);
    chk("no_unlock_in_lockout", 32'(unl), 32'd0);
    bus(1'b0, 4'd7, '0, 32'h32, 1'b0);
    idle();
    do_reset();
    chk("lockout_cleared", 32'(lko), 32'd0);
    chk("reglk_reset", 32'(reglk), 32'h00);
    bus(1'b0, 4'd2, '0, 32'h0, 1'b0);

    // Unlock after two bad tries; CHECK-cycle write still blocked
    bus(1'b1, 4'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus(1'b1, 4'd6, 32'h4, 32'h0, 1'b0);
    idle();
    bad_try(32'h10);
    bad_try(32'h20);
    jtag(KEY, 2, 1'b1, 1'b1);
    bus(1'b1, 4'd2, 32'h1111, 32'h0, 1'b1);
    idle();
    chk("unlocked_set", 32'(unl), 32'd1);
    bus(1'b0, 4'd7, '0, 32'h01, 1'b0);
    bus(1'b1, 4'd2, 32'hCAFE_0002, 32'h0, 1'b0);
    bus(1'b0, 4'd2, '0, 32'hCAFE_0002, 1'b0);
    bus(1'b0, 4'd6, '0, 32'h4, 1'b0);
    jtag(BAD, 1, 1'b1, 1'b1);
    idle();
    chk("reglk_kept_unlocked", 32'(reglk), 32'h04);
    bus(1'b1, 4'd7, 32'h1, 32'h0, 1'b0);
    idle();
    chk("relocked", 32'(unl), 32'd0);
    bus(1'b1, 4'd2, 32'h9, 32'h0, 1'b1);
    bus(1'b0, 4'd2, '0, 32'hCAFE_0002, 1'b0);
    bus(1'b0, 4'd7, '0, 32'h00, 1'b0);
    bus(1'b1, 4'd7, 32'h1, 32'h0, 1'b0);

    // Unmapped addresses
    bus(1'b0, 4'd12, '0, 32'h0, 1'b1);
    bus(1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0, 1'b1);
    idle();

    // Reset while the FSM is in CHECK drops the pending ack
    bad_try(32'h10);
    idle();
    jtag(BAD, 2, 1'b0, 1'b0);
    do_reset();
    idle();
    idle();
    chk("rst_check_unlocked", 32'(unl), 32'd0);
    chk("rst_check_lockout", 32'(lko), 32'd0);
    bus(1'b0, 4'd7, '0, 32'h00, 1'b0);
    repeat (3) idle();

    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("ack_queue_drained", 32'(jq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
